ed_32_edge: RTL and testbench
=============================

Name: ed_32_edge

Overview:
- Single-pixel Sobel edge classifier for a 3x3 grayscale neighbourhood centred on pixel (i,j).
- Computes horizontal and vertical gradients, takes an L1 magnitude, and compares it against a programmable 8-bit threshold.
- Produces one registered edge bit per clock.
- The image-tiling controller instantiates 16 copies; each copy sweeps one 32x32 tile of a zero-padded 128x128 image, one window per cycle.

Parameters:
- PIX_W, 8, pixel and threshold width in bits.
- MAG_W, PIX_W+3, magnitude width (11 bits at default); must hold 8*(2^PIX_W-1) without overflow.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- t  input  PIX_W  edge threshold, unsigned.
- IM_i_1_j_1  input  PIX_W  pixel (i-1, j-1).
- IM_i_1_j  input  PIX_W  pixel (i-1, j).
- IM_i_1_j__1  input  PIX_W  pixel (i-1, j+1).
- IM_i_j_1  input  PIX_W  pixel (i, j-1).
- IM_i_j  input  PIX_W  pixel (i, j); centre pixel, unused by Sobel but part of the interface.
- IM_i_j__1  input  PIX_W  pixel (i, j+1).
- IM_i__1_j_1  input  PIX_W  pixel (i+1, j-1).
- IM_i__1_j  input  PIX_W  pixel (i+1, j).
- IM_i__1_j__1  input  PIX_W  pixel (i+1, j+1).
- out  output  1  1 = edge at (i,j), registered.

Behaviour:
- Naming: "_1" = minus one, "__1" = plus one; first index is row i, second is column j. All pixels are unsigned.
- Gx = (IM_i_1_j__1 + 2*IM_i_j__1 + IM_i__1_j__1) - (IM_i_1_j_1 + 2*IM_i_j_1 + IM_i__1_j_1); signed, PIX_W+3 bits, range -1020..+1020 at default.
- Gy = (IM_i__1_j_1 + 2*IM_i__1_j + IM_i__1_j__1) - (IM_i_1_j_1 + 2*IM_i_1_j + IM_i_1_j__1); same width and range.
- mag = |Gx| + |Gy|; unsigned MAG_W bits, max 2040; never saturates or wraps.
- edge = (mag > {zero-extended t}); strictly greater, so mag == t gives 0.
- Latency: out is registered, and equals edge of the inputs and t sampled at the previous rising edge (1 cycle).
- Throughput: one new window accepted every cycle; no handshake and no stall.
- Reset: when reset=1 at a rising edge, out <= 0. The pipeline register is cleared; the first valid out appears one cycle after reset is deasserted.
- Reset mid-stream: the result in flight is discarded (out forced to 0); no other state exists.
- t may change every cycle; each window uses the t value sampled with it.
- t = 0: any nonzero gradient gives 1. Uniform windows always give 0 for every t.
- No X propagation requirements beyond the inputs being defined.

Optional Feature:
- Macro ED_PIPE2_EN.
- Defined: an extra register stage is added between the mag computation and the comparison.
  - The sampled t is delayed alongside mag.
  - Latency becomes 2 cycles and throughput stays 1 window per cycle.
  - Reset clears both stages, and out stays 0 for 2 cycles after reset release.
- Undefined: single-stage, latency 1 cycle, as in Behaviour.

Test Plan:
- Reset: hold reset=1 for 2 cycles with an edge window applied -> out=0 throughout. The first post-reset result appears on the 1st edge after release (2nd with ED_PIPE2_EN).
- Flat window, all 9 pixels = 100, t = 0 -> Gx = Gy = 0, out = 0.
- Vertical edge: left column = 0, right column = 255, centre column = 255, t = 200 -> Gx = 1020, Gy = 0, mag = 1020, out = 1.
- Threshold boundary: right column = 10, others = 0.
  - Gx = 40, mag = 40.
  - t = 40 -> out = 0.
  - t = 39 -> out = 1.
- Horizontal edge, negative gradient: top row = 50, other rows = 0 -> Gy = -200, mag = 200. t = 199 -> out = 1; t = 200 -> out = 0.
- Streaming: drive the four windows above on consecutive cycles with no gaps -> out reproduces each result, delayed by exactly the configured latency, with no bubbles.

Source files
------------

// File: rtl/ed_32_edge.sv
// Sobel 3x3 edge classifier: L1 gradient magnitude compared against threshold t.
// Define ED_PIPE2_EN to register mag and t before the compare (latency 2 instead of 1).
module ed_32_edge #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned MAG_W = PIX_W + 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] t,
  input  logic [PIX_W-1:0] IM_i_1_j_1,
  input  logic [PIX_W-1:0] IM_i_1_j,
  input  logic [PIX_W-1:0] IM_i_1_j__1,
  input  logic [PIX_W-1:0] IM_i_j_1,
  input  logic [PIX_W-1:0] IM_i_j,
  input  logic [PIX_W-1:0] IM_i_j__1,
  input  logic [PIX_W-1:0] IM_i__1_j_1,
  input  logic [PIX_W-1:0] IM_i__1_j,
  input  logic [PIX_W-1:0] IM_i__1_j__1,
  output logic             out
);

  // A weighted 1-2-1 sum of unsigned pixels needs two extra bits; the signed difference one more.
  localparam int unsigned SumW  = PIX_W + 2;
  localparam int unsigned GradW = PIX_W + 3;

  logic [SumW-1:0]         w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic signed [GradW-1:0] w_gx, w_gy;
  logic [SumW-1:0]         w_abs_x, w_abs_y;
  logic [MAG_W-1:0]        w_mag;
  logic                    w_unused;

  // The centre pixel has zero weight in both kernels.
  assign w_unused = ^IM_i_j;

  assign w_gx_pos = SumW'(IM_i_1_j__1) + (SumW'(IM_i_j__1) << 1) + SumW'(IM_i__1_j__1);
  assign w_gx_neg = SumW'(IM_i_1_j_1)  + (SumW'(IM_i_j_1)  << 1) + SumW'(IM_i__1_j_1);
  assign w_gy_pos = SumW'(IM_i__1_j_1) + (SumW'(IM_i__1_j) << 1) + SumW'(IM_i__1_j__1);
  assign w_gy_neg = SumW'(IM_i_1_j_1)  + (SumW'(IM_i_1_j)  << 1) + SumW'(IM_i_1_j__1);

  assign w_gx = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
  assign w_gy = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});

  // |G| never exceeds 4*(2^PIX_W-1), so it fits back into SumW bits.
  assign w_abs_x = w_gx[GradW-1] ? SumW'(-w_gx) : SumW'(w_gx);
  assign w_abs_y = w_gy[GradW-1] ? SumW'(-w_gy) : SumW'(w_gy);
  assign w_mag   = MAG_W'(w_abs_x) + MAG_W'(w_abs_y);

`ifdef ED_PIPE2_EN
  logic [MAG_W-1:0] r_mag;
  logic [PIX_W-1:0] r_t;
  logic             r_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mag <= '0;
      r_t   <= '0;
      r_out <= 1'b0;
    end else begin
      r_mag <= w_mag;
      r_t   <= t;
      r_out <= r_mag > MAG_W'(r_t);
    end
  end
`else
  logic r_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= 1'b0;
    end else begin
      r_out <= w_mag > MAG_W'(t);
    end
  end
`endif

  assign out = r_out;

endmodule

// File: tb/tb_ed_32_edge.sv
// Directed-vector bench for ed_32_edge, checked every cycle against an arithmetic Sobel model.
module tb_ed_32_edge;

`ifdef ED_PIPE2_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam int NV = 13;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] t;
  logic [7:0] px [9];
  logic       out;

  int n_vec = 0;
  int n_err = 0;

  int  vpix [NV][9];
  int  vt   [NV];
  bit  vexp [NV];

  int  pc = 0;
  bit  rst_h  [int];
  bit  edge_h [int];
  bit  run_cmp = 1'b0;

  always #5 clk = ~clk;

  ed_32_edge dut (
    .clk          (clk),
    .reset        (reset),
    .t            (t),
    .IM_i_1_j_1   (px[0]),
    .IM_i_1_j     (px[1]),
    .IM_i_1_j__1  (px[2]),
    .IM_i_j_1     (px[3]),
    .IM_i_j       (px[4]),
    .IM_i_j__1    (px[5]),
    .IM_i__1_j_1  (px[6]),
    .IM_i__1_j    (px[7]),
    .IM_i__1_j__1 (px[8]),
    .out          (out)
  );

  // Row-major window: index 3*(row+1)+(col+1), row/col offsets in {-1,0,+1}.
  function automatic bit model_edge(input int p[9], input int th);
    int gx, gy, mag;
    gx  = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
    gy  = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return mag > th;
  endfunction

  // Record what the DUT samples at each rising edge.
  always @(posedge clk) begin
    int p[9];
    for (int k = 0; k < 9; k++) p[k] = int'(px[k]);
    pc++;
    rst_h[pc]  = (reset === 1'b1);
    edge_h[pc] = model_edge(p, int'(t));
  end

  // After edge pc, out is 0 if reset was sampled in the last Lat edges, else the edge of the
  // window sampled Lat-1 edges earlier.
  always @(negedge clk) begin
    if (run_cmp) begin
      bit any_rst, known, exp_v;
      any_rst = 1'b0;
      known   = 1'b1;
      for (int d = 0; d < Lat; d++) begin
        if (pc - d < 1) known = 1'b0;
        else if (rst_h[pc - d]) any_rst = 1'b1;
      end
      if (any_rst || known) begin
        exp_v = any_rst ? 1'b0 : edge_h[pc - Lat + 1];
        n_vec++;
        if (out !== exp_v) begin
          n_err++;
          $display("FAIL cycle%0d out: got %b want %b", pc, out, exp_v);
        end
      end
    end
  end

  task automatic drive(input int p[9], input int th, input bit r);
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) px[k] = 8'(p[k]);
    t     = 8'(th);
    reset = r;
  endtask

  initial begin
    int rp[9];
    vpix[0]  = '{100, 100, 100, 100, 100, 100, 100, 100, 100}; vt[0]  = 0;   vexp[0]  = 0;
    vpix[1]  = '{0, 255, 255, 0, 255, 255, 0, 255, 255};       vt[1]  = 200; vexp[1]  = 1;
    vpix[2]  = '{0, 0, 10, 0, 0, 10, 0, 0, 10};                vt[2]  = 40;  vexp[2]  = 0;
    vpix[3]  = '{0, 0, 10, 0, 0, 10, 0, 0, 10};                vt[3]  = 39;  vexp[3]  = 1;
    vpix[4]  = '{50, 50, 50, 0, 0, 0, 0, 0, 0};                vt[4]  = 199; vexp[4]  = 1;
    vpix[5]  = '{50, 50, 50, 0, 0, 0, 0, 0, 0};                vt[5]  = 200; vexp[5]  = 0;
    vpix[6]  = '{255, 255, 255, 255, 255, 255, 255, 255, 255}; vt[6]  = 0;   vexp[6]  = 0;
    vpix[7]  = '{255, 0, 0, 0, 0, 0, 0, 0, 0};                 vt[7]  = 255; vexp[7]  = 1;
    vpix[8]  = '{0, 0, 255, 0, 0, 255, 255, 255, 255};         vt[8]  = 255; vexp[8]  = 1;
    vpix[9]  = '{0, 0, 0, 0, 255, 0, 0, 0, 0};                 vt[9]  = 0;   vexp[9]  = 0;
    vpix[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};                   vt[10] = 1;   vexp[10] = 1;
    vpix[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};                   vt[11] = 2;   vexp[11] = 0;
    vpix[12] = '{0, 0, 255, 0, 0, 255, 255, 255, 255};         vt[12] = 0;   vexp[12] = 1;

    // Pin the model against the hand-computed results.
    for (int v = 0; v < NV; v++) begin
      n_vec++;
      if (model_edge(vpix[v], vt[v]) != vexp[v]) begin
        n_err++;
        $display("FAIL model_vec%0d: got %b want %b", v, model_edge(vpix[v], vt[v]), vexp[v]);
      end
    end

    reset = 1'b1;
    t     = 8'd0;
    for (int k = 0; k < 9; k++) px[k] = 8'(vpix[1][k]);
    run_cmp = 1'b1;
    // Reset held two cycles with an edge window present.
    drive(vpix[1], 0, 1'b1);
    drive(vpix[1], 0, 1'b1);

    // Back-to-back directed stream starting right at release.
    drive(vpix[3], vt[3], 1'b0);
    for (int v = 0; v < NV; v++) drive(vpix[v], vt[v], 1'b0);
    // Streaming order from the plan: flat, vertical, threshold pair, horizontal pair.
    for (int v = 0; v < 6; v++) drive(vpix[v], vt[v], 1'b0);

    // Mid-stream reset discards results in flight.
    drive(vpix[1], vt[1], 1'b0);
    drive(vpix[3], vt[3], 1'b1);
    drive(vpix[1], vt[1], 1'b0);
    drive(vpix[8], vt[8], 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 9; k++) rp[k] = int'($urandom_range(0, 255));
      if (n % 4 == 0) for (int k = 0; k < 9; k++) rp[k] = rp[0] + (k > 5 ? 3 : 0);
      drive(rp, int'($urandom_range(0, 255)), 1'b0);
    end

    for (int n = 0; n < Lat + 1; n++) drive(vpix[0], 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
